// File: rtl/usbh_pkt_fifo_if.sv
// usbh_pkt_fifo_if: write/read port bundle for the packet-aware USB host FIFO.
//
// Handshake: a push is accepted on a rising clk_i edge when push_i && !full_o,
// and a pop is accepted when pop_i && !empty_o. Both qualifiers are sampled
// from the state before the edge. A strobe raised against the wrong flag is
// simply refused; the writer or reader keeps it up until the flag allows it.
// commit_i and rollback_i act on the whole pending packet on the same edge.
interface usbh_pkt_fifo_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 6
);
    logic [WIDTH-1:0]  data_i;
    logic              push_i;
    logic              commit_i;
    logic              rollback_i;
    logic              flush_i;
    logic              pop_i;
    logic [WIDTH-1:0]  data_o;
    logic              full_o;
    logic              empty_o;
    logic [ADDR_W:0]   level_o;
    logic [ADDR_W:0]   space_o;
    logic              afull_o;
    logic              aempty_o;
    logic              overflow_o;
    logic              underflow_o;

    // Writer/reader side: drives the strobes and data and observes the status.
    modport master (
        output data_i, push_i, commit_i, rollback_i, flush_i, pop_i,
        input  data_o, full_o, empty_o, level_o, space_o, afull_o, aempty_o,
               overflow_o, underflow_o
    );

    // FIFO side.
    modport slave (
        input  data_i, push_i, commit_i, rollback_i, flush_i, pop_i,
        output data_o, full_o, empty_o, level_o, space_o, afull_o, aempty_o,
               overflow_o, underflow_o
    );
endinterface

// File: rtl/usbh_pkt_fifo.sv
// usbh_pkt_fifo: packet-aware FIFO for USB host RX buffering.
// Words are pushed speculatively behind a committed write pointer. commit_i
// publishes the pending packet to the reader, and rollback_i discards it
// (a bad-CRC packet, for example). The reader sees committed words only, and
// data_o falls through combinationally from the RAM at the read pointer.
// Optional macro USBH_PKT_FIFO_ERR_EN builds sticky overflow/underflow flags.
// Without the macro, those flags are tied low.
module usbh_pkt_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 64,
    parameter int ADDR_W     = 6,
    parameter int AFULL_LVL  = 48,
    parameter int AEMPTY_LVL = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    usbh_pkt_fifo_if.slave  bus
);
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_LVL);
    localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_LVL);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] rd_ptr_q, wr_ptr_q, cwr_ptr_q;
    logic [CNT_W-1:0]  used_q, pend_q;

    logic              full_w, empty_w, push_ok, pop_ok;
    logic [CNT_W-1:0]  level_w;
    logic [ADDR_W-1:0] wr_adv;
    logic [CNT_W-1:0]  used_adv;

    // Status comes from registered state only. The write pointer and the
    // occupancy are advanced by the accepted push and pop.
    always_comb begin
        level_w  = used_q - pend_q;
        full_w   = (used_q == DEPTH_C);
        empty_w  = (level_w == '0);
        push_ok  = bus.push_i && !full_w;
        pop_ok   = bus.pop_i && !empty_w;
        wr_adv   = wr_ptr_q + ADDR_W'(push_ok);
        used_adv = used_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    // Storage write. The RAM holds no reset, so old contents survive a flush.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr_q] <= bus.data_i;
    end

    // Pointer and count update. Rollback takes priority over commit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            cwr_ptr_q <= '0;
            used_q    <= '0;
            pend_q    <= '0;
        end else if (bus.flush_i) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            cwr_ptr_q <= '0;
            used_q    <= '0;
            pend_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_q + ADDR_W'(pop_ok);
            if (bus.rollback_i) begin
                // The pending packet and any push in this cycle are dropped,
                // but a pop in this cycle still consumes a committed word.
                wr_ptr_q <= cwr_ptr_q;
                used_q   <= used_q - pend_q - CNT_W'(pop_ok);
                pend_q   <= '0;
            end else if (bus.commit_i) begin
                wr_ptr_q  <= wr_adv;
                cwr_ptr_q <= wr_adv;
                used_q    <= used_adv;
                pend_q    <= '0;
            end else begin
                wr_ptr_q <= wr_adv;
                used_q   <= used_adv;
                pend_q   <= pend_q + CNT_W'(push_ok);
            end
        end
    end

`ifdef USBH_PKT_FIFO_ERR_EN
    logic ovf_q, unf_q;

    // Sticky error flags. A full push is refused and flagged even when a pop
    // in the same cycle frees a slot.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (bus.flush_i) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (bus.push_i && full_w) ovf_q <= 1'b1;
            if (bus.pop_i && empty_w) unf_q <= 1'b1;
        end
    end

    assign bus.overflow_o  = ovf_q;
    assign bus.underflow_o = unf_q;
`else
    assign bus.overflow_o  = 1'b0;
    assign bus.underflow_o = 1'b0;
`endif

    assign bus.data_o   = mem[rd_ptr_q];
    assign bus.full_o   = full_w;
    assign bus.empty_o  = empty_w;
    assign bus.level_o  = level_w;
    assign bus.space_o  = DEPTH_C - used_q;
    assign bus.afull_o  = (used_q >= AFULL_C);
    assign bus.aempty_o = (level_w <= AEMPTY_C);
endmodule

// File: tb/tb_usbh_pkt_fifo.sv
// tb_usbh_pkt_fifo: directed packet scenarios plus randomized traffic.
// A queue model of committed and pending words sets the expected status and
// data on every cycle.
module tb_usbh_pkt_fifo;
    localparam int W = 8;
    localparam int D = 64;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    int   total = 0;
    int   bad   = 0;
    bit   run   = 1'b0;

    usbh_pkt_fifo_if #(.WIDTH(W), .ADDR_W(6)) bus ();

    usbh_pkt_fifo #(
        .WIDTH(W), .DEPTH(D), .ADDR_W(6), .AFULL_LVL(48), .AEMPTY_LVL(8)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;

    // ---------------- reference model ----------------
    logic [W-1:0] exp_q[$];   // committed words, oldest first
    logic [W-1:0] pend_q[$];  // pending (uncommitted) words
    bit m_ovf = 1'b0;
    bit m_unf = 1'b0;

    // Model update, evaluated on the pre-edge occupancy.
    always @(posedge clk_i or posedge rst_i) begin
        bit m_full, m_empty;
        if (rst_i) begin
            exp_q.delete(); pend_q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            m_full  = (exp_q.size() + pend_q.size()) == D;
            m_empty = (exp_q.size() == 0);
            if (bus.flush_i) begin
                exp_q.delete(); pend_q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
            end else begin
                if (bus.push_i && m_full) m_ovf = 1'b1;
                if (bus.pop_i && m_empty) m_unf = 1'b1;
                if (bus.pop_i && !m_empty) void'(exp_q.pop_front());
                if (bus.push_i && !m_full) pend_q.push_back(bus.data_i);
                if (bus.rollback_i) pend_q.delete();
                else if (bus.commit_i) begin
                    foreach (pend_q[i]) exp_q.push_back(pend_q[i]);
                    pend_q.delete();
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison on the falling edge, away from input changes.
    always @(negedge clk_i) begin
        int lvl, occ;
        if (run && !rst_i) begin
            lvl = exp_q.size();
            occ = exp_q.size() + pend_q.size();
            chk("empty_o",  32'(bus.empty_o),  32'(lvl == 0));
            chk("full_o",   32'(bus.full_o),   32'(occ == D));
            chk("level_o",  32'(bus.level_o),  32'(lvl));
            chk("space_o",  32'(bus.space_o),  32'(D - occ));
            chk("afull_o",  32'(bus.afull_o),  32'(occ >= 48));
            chk("aempty_o", 32'(bus.aempty_o), 32'(lvl <= 8));
`ifdef USBH_PKT_FIFO_ERR_EN
            chk("overflow_o",  32'(bus.overflow_o),  32'(m_ovf));
            chk("underflow_o", 32'(bus.underflow_o), 32'(m_unf));
`else
            chk("overflow_o",  32'(bus.overflow_o),  32'd0);
            chk("underflow_o", 32'(bus.underflow_o), 32'd0);
`endif
            if (lvl > 0) chk("data_o", 32'(bus.data_o), 32'(exp_q[0]));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input bit push, input logic [W-1:0] d, input bit pop,
                        input bit commit, input bit rollback, input bit flush);
        bus.push_i     = push;
        bus.data_i     = d;
        bus.pop_i      = pop;
        bus.commit_i   = commit;
        bus.rollback_i = rollback;
        bus.flush_i    = flush;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 do_reset();
        run = 1'b1;
        chk("rst empty", 32'(bus.empty_o), 32'd1);
        chk("rst space", 32'(bus.space_o), 32'd64);
        chk("rst aempty", 32'(bus.aempty_o), 32'd1);

        // 1: pending words are invisible until committed
        step(1, 8'h11, 0, 0, 0, 0);
        step(1, 8'h22, 0, 0, 0, 0);
        step(1, 8'h33, 0, 0, 0, 0);
        idle();
        chk("t1 empty pending", 32'(bus.empty_o), 32'd1);
        chk("t1 level pending", 32'(bus.level_o), 32'd0);
        chk("t1 space pending", 32'(bus.space_o), 32'd61);
        step(0, '0, 0, 1, 0, 0);
        chk("t1 level commit", 32'(bus.level_o), 32'd3);
        chk("t1 data commit", 32'(bus.data_o), 32'h11);
        repeat (3) step(0, '0, 1, 0, 0, 0);
        chk("t1 drained", 32'(bus.empty_o), 32'd1);

        // 2: rollback drops the pending packet only
        step(1, 8'hA0, 0, 0, 0, 0);
        step(1, 8'hA1, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 8'hB0 + W'(i), 0, 0, 0, 0);
        step(0, '0, 0, 0, 1, 0);
        chk("t2 level", 32'(bus.level_o), 32'd2);
        chk("t2 space", 32'(bus.space_o), 32'd62);
        chk("t2 data0", 32'(bus.data_o), 32'hA0);
        step(0, '0, 1, 0, 0, 0);
        chk("t2 data1", 32'(bus.data_o), 32'hA1);
        step(0, '0, 1, 0, 0, 0);
        chk("t2 empty", 32'(bus.empty_o), 32'd1);

        // 3: fill to full, then a refused push alongside a pop
        for (int i = 0; i < 64; i++) step(1, W'(i), 0, i == 63, 0, 0);
        chk("t3 full", 32'(bus.full_o), 32'd1);
        chk("t3 level", 32'(bus.level_o), 32'd64);
        chk("t3 afull", 32'(bus.afull_o), 32'd1);
        step(1, 8'hEE, 1, 0, 0, 0);
        chk("t3 level after", 32'(bus.level_o), 32'd63);
        chk("t3 full after", 32'(bus.full_o), 32'd0);
`ifdef USBH_PKT_FIFO_ERR_EN
        chk("t3 overflow", 32'(bus.overflow_o), 32'd1);
`endif

        // 4: steady state across pointer wrap
        repeat (53) step(0, '0, 1, 0, 0, 0);
        chk("t4 level start", 32'(bus.level_o), 32'd10);
        for (int i = 0; i < 200; i++) step(1, W'($urandom_range(0, 255)), 1, 1, 0, 0);
        chk("t4 level end", 32'(bus.level_o), 32'd10);

        // 5: commit and rollback together with a push discard all four words
        for (int i = 0; i < 3; i++) step(1, 8'hC0 + W'(i), 0, 0, 0, 0);
        step(1, 8'hC3, 0, 1, 1, 0);
        chk("t5 level", 32'(bus.level_o), 32'd10);
        chk("t5 space", 32'(bus.space_o), 32'd54);

        // 6: flush mid-packet, then asynchronous reset mid-push
        step(1, 8'hD0, 0, 0, 0, 0);
        step(1, 8'hD1, 0, 0, 0, 1);
        chk("t6 flush empty", 32'(bus.empty_o), 32'd1);
        chk("t6 flush space", 32'(bus.space_o), 32'd64);
        step(0, '0, 1, 0, 0, 0);   // pop on empty
        step(1, 8'hD2, 0, 0, 0, 0);
        bus.push_i = 1'b1;
        #2 rst_i = 1'b1;
        #1;
        chk("t6 rst empty", 32'(bus.empty_o), 32'd1);
        chk("t6 rst space", 32'(bus.space_o), 32'd64);
        chk("t6 rst level", 32'(bus.level_o), 32'd0);
        chk("t6 rst underflow", 32'(bus.underflow_o), 32'd0);
        idle();
        @(posedge clk_i);
        #1 rst_i = 1'b0;

        // randomized traffic in phases of varying push bias
        for (int ph = 0; ph < 10; ph++) begin
            int push_pct;
            push_pct = $urandom_range(20, 90);
            for (int i = 0; i < 150; i++) begin
                step($urandom_range(0, 99) < push_pct, W'($urandom_range(0, 255)),
                     $urandom_range(0, 99) < 50, $urandom_range(0, 5) == 0,
                     $urandom_range(0, 15) == 0, $urandom_range(0, 127) == 0);
            end
        end
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/usbh_pkt_fifo.md
Name: usbh_pkt_fifo

Overview:
Parametrised packet-aware FIFO for the USB host datapath (RX token/data buffering between the PHY-side packet engine and the bus-side reader). Writes are speculative until the writer commits them. A rollback discards an uncommitted packet, for example one that failed CRC. The reader only ever sees committed words. Level and threshold outputs support DMA/IRQ pacing.

Parameters:
WIDTH, 8, data word width in bits
DEPTH, 64, storage entries; must equal 2**ADDR_W
ADDR_W, 6, pointer width
AFULL_LVL, 48, afull_o asserts when occupied entries (committed + pending) >= AFULL_LVL
AEMPTY_LVL, 8, aempty_o asserts when committed level <= AEMPTY_LVL

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
data_i  in  WIDTH  write data
push_i  in  1  write strobe; accepted when !full_o
commit_i  in  1  make all pending words (incl. a same-cycle push) visible to the reader
rollback_i  in  1  discard all pending words (incl. a same-cycle push)
flush_i  in  1  synchronous clear of all state
pop_i  in  1  read strobe; accepted when !empty_o
data_o  out  WIDTH  word at read pointer (first-word-fall-through, combinational from RAM)
full_o  out  1  occupied == DEPTH
empty_o  out  1  committed level == 0
level_o  out  ADDR_W+1  committed words available to the reader
space_o  out  ADDR_W+1  DEPTH - occupied
afull_o  out  1  almost full (see AFULL_LVL)
aempty_o  out  1  almost empty (see AEMPTY_LVL)
overflow_o  out  1  sticky: push while full (feature-gated)
underflow_o  out  1  sticky: pop while empty (feature-gated)

Behaviour:
- State: rd_ptr_q, wr_ptr_q (speculative), cwr_ptr_q (committed write pointer); used_q (occupied, ADDR_W+1 bits); pend_q (pending, ADDR_W+1 bits). level_o = used_q - pend_q.
- Reset (async) and flush_i (sync): all pointers and counts 0. Outputs: empty_o=1, full_o=0, level_o=0, space_o=DEPTH, afull_o=0, aempty_o=1, sticky flags 0. RAM contents are not cleared.
- Priority: rst_i > flush_i > rollback_i > commit_i. When commit_i and rollback_i are both high, rollback applies and commit is ignored.
- Push accepted (push_i && !full_o):
  - ram[wr_ptr_q] <= data_i
  - wr_ptr_q increments modulo DEPTH
  - pend_q increments
  - used_q increments
- Pop accepted (pop_i && !empty_o):
  - rd_ptr_q increments
  - used_q decrements
- Push and pop in the same cycle: used_q is unchanged net. full_o and empty_o are always evaluated on the pre-edge state. A push when full is refused even if a pop occurs in the same cycle.
- Commit: cwr_ptr_q <= next wr_ptr (including any same-cycle accepted push); pend_q <= 0. data_o/level_o reflect the committed words one cycle after the edge. Commit with pend_q==0 and no push is a no-op.
- Rollback:
  - wr_ptr_q <= cwr_ptr_q
  - used_q <= used_q - pend_q (same-cycle push discarded; same-cycle pop still applied)
  - pend_q <= 0
- Latency: a committed word is poppable on the cycle after the commit edge. data_o is valid whenever !empty_o.
- Pointer wrap: natural ADDR_W-bit wrap. Counts never exceed DEPTH.
- All outputs are derived combinationally from registered state only. There are no combinational paths from inputs to outputs.

Optional Feature:
USBH_PKT_FIFO_ERR_EN
- Defined:
  - overflow_o sets on push_i && full_o.
  - underflow_o sets on pop_i && empty_o.
  - Both are sticky until rst_i or flush_i.
  - A push refused by full sets overflow even if a pop occurs in the same cycle.
- Undefined: overflow_o and underflow_o are tied 0 and no flag registers are built.

Test Plan:
1. Reset, push 0x11,0x22,0x33 without commit -> empty_o=1, level_o=0, space_o=61. Then commit -> next cycle level_o=3, data_o=0x11.
2. Commit 2 words. Push 5 pending words, then rollback -> level_o=2, space_o=62. Pop twice -> 0xA0,0xA1, then empty_o=1.
3. Push 64 words, commit on the last push -> full_o=1, level_o=64, afull_o=1. Push+pop in the same cycle -> push refused, level_o=63. With ERR_EN, overflow_o=1.
4. Steady state, level 10: push+pop in the same cycle for 200 cycles across pointer wrap -> level_o stays 10, data order is preserved.
5. Pending 3, commit_i and rollback_i high together with a push -> all 4 words discarded, level unchanged.
6. Mid-packet flush_i, then assert rst_i asynchronously mid-push -> all state zero, empty_o=1, space_o=64, and sticky flags cleared.
